n_sum: RTL and testbench

- Computes the triangular sum 1+2+…+N for a 3-bit input N, one addition per clock.
- Presents the 4-bit result with a valid/acknowledge handshake.
- Built from three cooperating FSMs: input capture, accumulate, output handshake.
- Standalone arithmetic sequencer for small control-path computations.

---
 rtl/n_sum.sv | 129 ++++++++++++
 tb/tb_n_sum.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/n_sum.sv
// Triangular sum 1+2+...+N sequencer: input capture, accumulate and
// output handshake FSMs, one addition per clock.
module n_sum (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] N,
    input  logic       N_valid,
    input  logic       Ack,
    output logic [3:0] sum,
    output logic       sum_valid
);

    typedef enum logic {
        IN_IDLE,
        IN_BUSY
    } in_state_t;

    typedef enum logic [1:0] {
        AC_IDLE,
        AC_ADD,
        AC_DONE
    } ac_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_HOLD
    } out_state_t;

    in_state_t  in_q,  in_d;
    ac_state_t  ac_q,  ac_d;
    out_state_t out_q, out_d;

    logic [2:0] cnt_q, cnt_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] sum_q, sum_d;
    logic       valid_q, valid_d;

    logic start;
    logic ack_take;
    logic load;

    always_comb begin
        start    = (in_q == IN_IDLE) && N_valid;
        ack_take = (out_q == OUT_HOLD) && Ack;
        load     = (ac_q == AC_DONE);
    end

    // Input FSM stays busy from acceptance until the result is acknowledged.
    always_comb begin
        in_d = in_q;
        unique case (in_q)
            IN_IDLE: if (start) in_d = IN_BUSY;
            IN_BUSY: if (ack_take) in_d = IN_IDLE;
            default: in_d = IN_IDLE;
        endcase
    end

    always_comb begin
        ac_d  = ac_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        unique case (ac_q)
            AC_IDLE: begin
                if (start) begin
                    cnt_d = N;
                    acc_d = 4'd0;
                    ac_d  = AC_ADD;
                end
            end
            AC_ADD: begin
                if (cnt_q != 3'd0) begin
                    acc_d = acc_q + {1'b0, cnt_q};
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) ac_d = AC_DONE;
                end else begin
                    ac_d = AC_DONE;
                end
            end
            AC_DONE: ac_d = AC_IDLE;
            default: ac_d = AC_IDLE;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        unique case (out_q)
            OUT_IDLE: begin
                if (load) begin
                    sum_d   = acc_q;
                    valid_d = 1'b1;
                    out_d   = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (Ack) begin
                    valid_d = 1'b0;
                    out_d   = OUT_IDLE;
                end
            end
            default: out_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q    <= IN_IDLE;
            ac_q    <= AC_IDLE;
            out_q   <= OUT_IDLE;
            cnt_q   <= 3'd0;
            acc_q   <= 4'd0;
            sum_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            in_q    <= in_d;
            ac_q    <= ac_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = valid_q;

endmodule

// File: tb/tb_n_sum.sv
// Directed and randomized checks of n_sum against a closed-form
// triangular-number model with latency max(N,1)+1.
module tb_n_sum;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] N;
    logic       N_valid;
    logic       Ack;
    logic [3:0] sum;
    logic       sum_valid;

    int tests  = 0;
    int failed = 0;
    logic [3:0] exp_sum;

    n_sum dut (
        .clk       (clk),
        .reset     (reset),
        .N         (N),
        .N_valid   (N_valid),
        .Ack       (Ack),
        .sum       (sum),
        .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] tri_sum(input int n);
        return 4'((n * (n + 1) / 2) % 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v);
        chk({tag, "_valid"}, {3'b0, sum_valid}, {3'b0, v});
        chk({tag, "_sum"}, sum, exp_sum);
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk_out(tag, 1'b0);
        end
    endtask

    task automatic hold(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk_out(tag, 1'b1);
        end
    endtask

    task automatic do_ack(input string tag);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_out(tag, 1'b0);
    endtask

    // Issue a request for n and check the result appears exactly at
    // edge k+max(n,1)+1 and nothing changes before that.
    task automatic run_req(input int n, input bit ack_at_a,
                           input bit drop, input string tag);
        int lat;
        lat = (n == 0) ? 2 : n + 1;
        if (ack_at_a) begin
            Ack     = 1'b1;
            N_valid = 1'b1;
            N       = 3'(~n);
            tick();
            Ack = 1'b0;
            chk_out({tag, "_acka"}, 1'b0);
        end
        N       = 3'(n);
        N_valid = 1'b1;
        tick();
        N_valid = 1'b0;
        N       = 3'($urandom);
        chk_out({tag, "_acc"}, 1'b0);
        for (int i = 1; i < lat; i++) begin
            if (drop && i == 2) begin
                N_valid = 1'b1;
                N       = 3'd4;
            end
            tick();
            N_valid = 1'b0;
            chk_out({tag, "_busy"}, 1'b0);
        end
        exp_sum = tri_sum(n);
        tick();
        chk_out({tag, "_res"}, 1'b1);
    endtask

    initial begin
        int n;
        exp_sum = 4'd0;
        N       = 3'd5;
        N_valid = 1'b1;
        Ack     = 1'b0;
        reset   = 1'b1;
        tick();
        chk_out("reset", 1'b0);
        reset   = 1'b0;
        N_valid = 1'b0;
        idle(8, "post_reset");

        run_req(5, 1'b0, 1'b1, "basic5");
        N_valid = 1'b1;
        N       = 3'd4;
        tick();
        N_valid = 1'b0;
        chk_out("hold_drop", 1'b1);
        hold(8, "hold5");
        do_ack("ack5");
        idle(12, "no_second");

        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_out("stray_ack", 1'b0);
        run_req(3, 1'b0, 1'b0, "n3");
        hold(2, "hold3");

        run_req(4, 1'b1, 1'b0, "b2b4");
        hold(1, "hold4");
        Ack     = 1'b1;
        N_valid = 1'b1;
        N       = 3'd7;
        tick();
        Ack     = 1'b0;
        N_valid = 1'b0;
        chk_out("ack_req_only", 1'b0);
        idle(10, "ack_req_ign");

        run_req(0, 1'b0, 1'b0, "n0");
        do_ack("ack0");
        run_req(7, 1'b0, 1'b0, "n7");
        do_ack("ack7");
        run_req(6, 1'b0, 1'b0, "n6");
        do_ack("ack6");

        N       = 3'd5;
        N_valid = 1'b1;
        tick();
        N_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_sum = 4'd0;
        chk_out("abort", 1'b0);
        idle(10, "abort_idle");
        run_req(1, 1'b0, 1'b0, "after_abort");
        do_ack("ack1");

        for (int r = 0; r < 25; r++) begin
            n = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                Ack = 1'b1;
                tick();
                Ack = 1'b0;
                chk_out("rnd_stray", 1'b0);
            end
            run_req(n, 1'b0, 1'b0, "rnd");
            hold(int'($urandom_range(0, 3)), "rnd_hold");
            do_ack("rnd_ack");
            idle(int'($urandom_range(0, 2)), "rnd_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
